// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//
// Bundles the button-side signals of the button conditioner. Clock and reset
// are kept outside as plain ports on the conditioner itself.
//
// Signals:
//   Btn         raw, asynchronous, possibly bouncing button level
//   Pressed     debounced button level
//   Pulse       one-cycle strobe on an accepted press
//   Release     one-cycle strobe on an accepted release
//   PressCount  accepted presses, modulo 2**COUNT_WIDTH
//
// Modports:
//   slave   the conditioner (consumes Btn, produces the conditioned outputs)
//   master  whatever drives the button and consumes the outputs
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   Btn;
    logic                   Pressed;
    logic                   Pulse;
    logic                   Release;
    logic [COUNT_WIDTH-1:0] PressCount;

    modport slave (
        input  Btn,
        output Pressed,
        output Pulse,
        output Release,
        output PressCount
    );

    modport master (
        output Btn,
        input  Pressed,
        input  Pulse,
        input  Release,
        input  PressCount
    );
endinterface : button_conditioner_if

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for a mechanical push button. The raw level is brought into the
// Clk domain through a two-flop synchronizer, then debounced by a four-state
// FSM that only accepts a level change after DEBOUNCE_CYCLES consecutive
// stable synchronized samples. Accepted presses produce a one-cycle Pulse
// (the strobe the downstream flip-flop stage uses as its enable), accepted
// releases a one-cycle Release, and a wrapping counter tracks the presses.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples required to accept a change (>= 1)
//   COUNT_WIDTH      width of PressCount
//
// Ports:
//   Clk       system clock, all state updates on the rising edge
//   notReset  asynchronous, active-low reset
//   bus       button_conditioner_if.slave (Btn in; Pressed, Pulse, Release,
//             PressCount out)
//
// Every output comes straight from a flop; nothing is combinational from Btn.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                    Clk,
    input  logic                    notReset,
    button_conditioner_if.slave     bus
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizer
    // -------------------------------------------------------------------------
    logic r_btn_s1;
    logic r_btn_sync;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbours; a blocking '='
    // here would collapse the two synchronizer stages into one.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            r_btn_s1   <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_btn_s1   <= bus.Btn;
            r_btn_sync <= r_btn_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: state register
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept_press;
    logic             w_accept_release;

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: next state and counter
    //
    // The WAIT states count how many consecutive samples BtnSync has agreed
    // with the candidate level. Entering a WAIT state already accounts for the
    // sample that triggered the entry, hence cnt starts at 1. Any disagreement
    // sends the FSM straight back to the level it came from.
    // -------------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so each path
    // through the case leaves it defined and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (r_btn_sync) begin
                    w_state_next = ST_PRESS_WAIT;
                    w_cnt_next   = CNT_ONE;
                end
            end

            ST_PRESS_WAIT: begin
                if (!r_btn_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next   = ST_HELD;
                    w_cnt_next     = CNT_ZERO;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            ST_HELD: begin
                if (!r_btn_sync) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_cnt_next   = CNT_ONE;
                end
            end

            ST_RELEASE_WAIT: begin
                if (r_btn_sync) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next     = ST_IDLE;
                    w_cnt_next       = CNT_ZERO;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    //
    // Outputs are computed from the next state so they line up with the state
    // register: Pressed is high in exactly the cycles where the state is HELD
    // or RELEASE_WAIT, and the strobes are high in the single cycle following
    // the accepting edge. The two accept conditions come from different
    // states, so Pulse and Release can never coincide.
    // -------------------------------------------------------------------------
    logic                   r_pressed;
    logic                   r_pulse;
    logic                   r_release;
    logic [COUNT_WIDTH-1:0] r_press_count;

    logic w_pressed_next;

    always_comb begin
        w_pressed_next = (w_state_next == ST_HELD) ||
                         (w_state_next == ST_RELEASE_WAIT);
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            r_pressed     <= 1'b0;
            r_pulse       <= 1'b0;
            r_release     <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_pressed <= w_pressed_next;
            r_pulse   <= w_accept_press;
            r_release <= w_accept_release;
            // Wraps silently at 2**COUNT_WIDTH.
            if (w_accept_press) begin
                r_press_count <= r_press_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.Pressed    = r_pressed;
    assign bus.Pulse      = r_pulse;
    assign bus.Release    = r_release;
    assign bus.PressCount = r_press_count;

endmodule : button_conditioner
